// File: rtl/axi_str_rr_arbiter.sv
// Packet-granular round-robin arbiter: merges NUM_PORTS AXI-Stream inputs onto one
// registered AXI-Stream output, holding the grant from first beat through tlast.
module axi_str_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_SIZE = 32,
  parameter int USER_SIZE = 8,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_PORTS-1:0]              s_tvalid,
  output logic [NUM_PORTS-1:0]              s_tready,
  input  logic [NUM_PORTS-1:0]              s_tlast,
  input  logic [NUM_PORTS*DATA_SIZE-1:0]    s_tdata,
  input  logic [NUM_PORTS*DATA_SIZE/8-1:0]  s_tkeep,
  input  logic [NUM_PORTS*USER_SIZE-1:0]    s_tuser,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic [DATA_SIZE-1:0]              m_tdata,
  output logic [DATA_SIZE/8-1:0]            m_tkeep,
  output logic [USER_SIZE-1:0]              m_tuser,
  output logic [ID_W-1:0]                   m_tid,
  output logic                              busy,
  output logic [ID_W-1:0]                   grant_id
);

  localparam int              KEEP_W  = DATA_SIZE / 8;
  localparam logic [0:0]      ST_IDLE = 1'b0;
  localparam logic [0:0]      ST_PKT  = 1'b1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PORTS - 1);

  logic [0:0]      state;
  logic [ID_W-1:0] ptr;
  logic            out_free;
  logic            xfer;
  logic            req_any;
  logic [ID_W-1:0] req_idx;
  logic [ID_W-1:0] cand;

  logic [DATA_SIZE-1:0] data_arr [NUM_PORTS];
  logic [KEEP_W-1:0]    keep_arr [NUM_PORTS];
  logic [USER_SIZE-1:0] user_arr [NUM_PORTS];

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      data_arr[i] = s_tdata[i*DATA_SIZE +: DATA_SIZE];
      keep_arr[i] = s_tkeep[i*KEEP_W +: KEEP_W];
      user_arr[i] = s_tuser[i*USER_SIZE +: USER_SIZE];
    end
  end

  // Output stage can accept a beat when empty or being drained this cycle.
  assign out_free = !m_tvalid || m_tready;
  assign busy     = (state == ST_PKT);
  assign xfer     = busy && s_tvalid[grant_id] && out_free;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    s_tready = '0;
    if (busy) s_tready[grant_id] = out_free;
  end

  // Scan from the farthest offset down so the lowest offset from ptr wins.
  always_comb begin
    req_any = 1'b0;
    req_idx = ptr;
    cand    = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_PORTS);
      if (s_tvalid[cand]) begin
        req_any = 1'b1;
        req_idx = cand;
      end
    end
  end

  // reset_n is expected to arrive with its deassertion already synchronized to clk.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant_id <= '0;
    end else if (state == ST_IDLE) begin
      if (req_any) begin
        grant_id <= req_idx;
        state    <= ST_PKT;
      end
    end else if (xfer && s_tlast[grant_id]) begin
      state <= ST_IDLE;
      ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tuser  <= '0;
      m_tid    <= '0;
    end else if (xfer) begin
      m_tvalid <= 1'b1;
      m_tlast  <= s_tlast[grant_id];
      m_tdata  <= data_arr[grant_id];
      m_tkeep  <= keep_arr[grant_id];
      m_tuser  <= user_arr[grant_id];
      m_tid    <= grant_id;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_str_rr_arbiter.sv
// Self-checking bench for axi_str_rr_arbiter: directed scenarios plus randomized
// traffic scored against a packet-level round-robin reference model.
module tb_axi_str_rr_arbiter;

  localparam int NUM = 4;
  localparam int DW  = 32;
  localparam int UW  = 8;
  localparam int KW  = DW / 8;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
  } beat_t;

  logic              clk;
  logic              reset_n;
  logic [NUM-1:0]    s_tvalid;
  logic [NUM-1:0]    s_tready;
  logic [NUM-1:0]    s_tlast;
  logic [NUM*DW-1:0] s_tdata;
  logic [NUM*KW-1:0] s_tkeep;
  logic [NUM*UW-1:0] s_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic [1:0]        m_tid;
  logic              busy;
  logic [1:0]        grant_id;

  int checks = 0;
  int errors = 0;

  logic [46:0] out_vec;
  assign out_vec = {m_tlast, m_tdata, m_tkeep, m_tuser, m_tid};

  axi_str_rr_arbiter #(
    .NUM_PORTS(NUM), .DATA_SIZE(DW), .USER_SIZE(UW), .ID_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
    .m_tid(m_tid), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Directed beats derive tkeep/tuser from the data word so one word describes a beat.
  function automatic logic [46:0] exp_vec(input logic l, input logic [31:0] d, input logic [1:0] id);
    return {l, d, d[3:0], d[15:8], id};
  endfunction

  task automatic drive_beat(input int p, input logic v, input beat_t b);
    s_tvalid[p]          = v;
    s_tlast[p]           = b.last;
    s_tdata[p*DW +: DW]  = b.data;
    s_tkeep[p*KW +: KW]  = b.keep;
    s_tuser[p*UW +: UW]  = b.user;
  endtask

  task automatic drive(input int p, input logic v, input logic l, input logic [31:0] d);
    beat_t b;
    b.last = l; b.data = d; b.keep = d[3:0]; b.user = d[15:8];
    drive_beat(p, v, b);
  endtask

  // Returns at a falling edge just after reset release: that cycle is cycle 0.
  task automatic apply_reset();
    reset_n  = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
    m_tready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({m_tvalid, out_vec, busy, grant_id, s_tready} !== '0) begin
      errors++;
      $display("FAIL reset_values: got v=%b vec=%h busy=%b gid=%0d rdy=%b, want all zero",
               m_tvalid, out_vec, busy, grant_id, s_tready);
    end
    s_tvalid = '1;
    #1;
    checks++;
    if (s_tready !== 4'b0000) begin
      errors++;
      $display("FAIL idle_no_ready: got s_tready=%b want 0000", s_tready);
    end
    s_tvalid = '0;
  endtask

  task automatic test_single();
    apply_reset();
    drive(0, 1, 0, 32'hA000_1101); #1;
    checks++;
    if ({busy, s_tready} !== 5'b0_0000) begin
      errors++; $display("FAIL single_c0: got busy=%b rdy=%b want 0 0000", busy, s_tready);
    end
    @(negedge clk); #1;
    checks++;
    if ({busy, grant_id, s_tready, m_tvalid} !== {1'b1, 2'd0, 4'b0001, 1'b0}) begin
      errors++; $display("FAIL single_c1: got busy=%b gid=%0d rdy=%b v=%b", busy, grant_id, s_tready, m_tvalid);
    end
    @(negedge clk); drive(0, 1, 0, 32'hA001_2202); #1;
    checks++;
    if ({s_tready, m_tvalid, out_vec} !== {4'b0001, 1'b1, exp_vec(0, 32'hA000_1101, 0)}) begin
      errors++; $display("FAIL single_c2: got rdy=%b v=%b vec=%h", s_tready, m_tvalid, out_vec);
    end
    @(negedge clk); drive(0, 1, 1, 32'hA002_3303); #1;
    checks++;
    if ({s_tready, m_tvalid, out_vec} !== {4'b0001, 1'b1, exp_vec(0, 32'hA001_2202, 0)}) begin
      errors++; $display("FAIL single_c3: got rdy=%b v=%b vec=%h", s_tready, m_tvalid, out_vec);
    end
    @(negedge clk); drive(0, 0, 0, 0); #1;
    checks++;
    if ({busy, s_tready, m_tvalid, out_vec} !== {1'b0, 4'b0000, 1'b1, exp_vec(1, 32'hA002_3303, 0)}) begin
      errors++; $display("FAIL single_c4: got busy=%b rdy=%b v=%b vec=%h", busy, s_tready, m_tvalid, out_vec);
    end
    @(negedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL single_c5: got m_tvalid=%b want 0", m_tvalid);
    end
  endtask

  task automatic test_round_robin();
    int n;
    apply_reset();
    for (int p = 0; p < NUM; p++) drive(p, 1, 1, 32'h0000_C0C0 + p);
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({m_tvalid, busy} !== {(c >= 2 && c % 2 == 0), (c % 2 == 1)}) begin
        errors++; $display("FAIL rr_timing c%0d: got v=%b busy=%b", c, m_tvalid, busy);
      end
      if (c >= 2 && c % 2 == 0) begin
        n = (c / 2 - 1) % NUM;
        checks++;
        if (out_vec !== exp_vec(1, 32'h0000_C0C0 + n, 2'(n))) begin
          errors++; $display("FAIL rr_order c%0d: got vec=%h want port %0d", c, out_vec, n);
        end
      end
    end
    s_tvalid = '0;
  endtask

  task automatic test_packet_lock();
    logic [46:0] exp_l [5];
    logic [31:0] bd [4];
    int got = 0;
    bit p2_done = 0;
    bd[0] = 32'hB000_1111; bd[1] = 32'hB001_2222; bd[2] = 32'hB002_3333; bd[3] = 32'hB003_4444;
    for (int i = 0; i < 4; i++) exp_l[i] = exp_vec(i == 3, bd[i], 1);
    exp_l[4] = exp_vec(1, 32'hC200_5555, 2);
    apply_reset();
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      case (c)
        0, 1:    drive(1, 1, 0, bd[0]);
        2:       drive(1, 1, 0, bd[1]);
        5:       drive(1, 1, 0, bd[2]);
        6:       drive(1, 1, 1, bd[3]);
        default: drive(1, 0, 0, 0);
      endcase
      drive(2, !p2_done, 1, 32'hC200_5555);
      #1;
      checks++;
      if (s_tready[1] !== (c >= 1 && c <= 6) || (c <= 6 && s_tready[2] !== 1'b0)) begin
        errors++; $display("FAIL lock_ready c%0d: got s_tready=%b", c, s_tready);
      end
      if (s_tvalid[2] && s_tready[2]) p2_done = 1;
      if (m_tvalid) begin
        checks++;
        if (got >= 5 || out_vec !== exp_l[got]) begin
          errors++; $display("FAIL lock_order beat%0d: got vec=%h", got, out_vec);
        end
        got++;
      end
    end
    checks++;
    if (got !== 5) begin
      errors++; $display("FAIL lock_count: got %0d beats want 5", got);
    end
    s_tvalid = '0;
  endtask

  task automatic test_backpressure();
    logic [31:0] dv [4];
    int idx = 0;
    int got = 0;
    dv[0] = 32'hD000_0A01; dv[1] = 32'hD001_0B02; dv[2] = 32'hD002_0C03; dv[3] = 32'hD003_0D04;
    apply_reset();
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      if (idx < 4) drive(0, 1, idx == 3, dv[idx]);
      else         drive(0, 0, 0, 0);
      m_tready = !(c >= 3 && c <= 6);
      #1;
      if (c >= 3 && c <= 6) begin
        checks++;
        if ({s_tready, m_tvalid, out_vec} !== {4'b0000, 1'b1, exp_vec(0, dv[1], 0)}) begin
          errors++; $display("FAIL bp_stall c%0d: got rdy=%b v=%b vec=%h", c, s_tready, m_tvalid, out_vec);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (got >= 4 || out_vec !== exp_vec(got == 3, dv[got], 0)) begin
          errors++; $display("FAIL bp_order beat%0d: got vec=%h", got, out_vec);
        end
        got++;
      end
      if (s_tvalid[0] && s_tready[0]) idx++;
    end
    m_tready = 1'b1;
    checks++;
    if (got !== 4) begin
      errors++; $display("FAIL bp_count: got %0d beats want 4", got);
    end
  endtask

  task automatic test_ptr_wrap();
    apply_reset();
    drive(3, 1, 1, 32'hE300_0001);
    @(negedge clk); #1;
    checks++;
    if ({grant_id, s_tready} !== {2'd3, 4'b1000}) begin
      errors++; $display("FAIL wrap_grant3: got gid=%0d rdy=%b", grant_id, s_tready);
    end
    @(negedge clk);
    drive(0, 1, 1, 32'hF000_0002);
    drive(3, 1, 1, 32'hE300_0003);
    @(negedge clk); #1;
    checks++;
    if ({busy, grant_id, s_tready} !== {1'b1, 2'd0, 4'b0001}) begin
      errors++; $display("FAIL wrap_grant0: got busy=%b gid=%0d rdy=%b want 1 0 0001", busy, grant_id, s_tready);
    end
    s_tvalid = '0;
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    drive(2, 1, 1, 32'h6200_0001);          // ends on port 2 so the pointer moves to 3
    @(negedge clk);
    @(negedge clk); drive(2, 0, 0, 0); drive(1, 1, 0, 32'h4100_0010);
    @(negedge clk); #1;
    checks++;
    if ({busy, grant_id} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL rstmid_grant: got busy=%b gid=%0d want 1 1", busy, grant_id);
    end
    @(negedge clk); drive(1, 1, 0, 32'h4101_0020); #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, out_vec, busy, grant_id, s_tready} !== '0) begin
      errors++; $display("FAIL rstmid_clear: got v=%b vec=%h busy=%b gid=%0d rdy=%b",
                         m_tvalid, out_vec, busy, grant_id, s_tready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 1, 1, 32'h4102_0030);
    drive(3, 1, 1, 32'h4300_0040);
    #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_abandon: got m_tvalid=%b want 0", m_tvalid);
    end
    @(negedge clk); #1;
    checks++;
    if ({busy, grant_id, s_tready} !== {1'b1, 2'd1, 4'b0010}) begin
      errors++; $display("FAIL rstmid_ptr0: got busy=%b gid=%0d rdy=%b want 1 1 0010", busy, grant_id, s_tready);
    end
    s_tvalid = '0;
  endtask

  // Reference: inputs hold each packet's first beat until granted, so arbitration
  // reduces to plain round robin over ports that still have packets left.
  task automatic test_random();
    beat_t src_q [NUM][$];
    beat_t exp_b [$];
    int    exp_id [$];
    int    rem [NUM];
    int    pos [NUM];
    bit    started [NUM];
    bit    xf [NUM];
    int    total = 0;
    int    ptr_m = 0;
    int    sel;
    bit    found;
    bit    hold_v = 0;
    logic [47:0] held = '0;
    beat_t x;
    beat_t eb;
    int    eid;

    for (int p = 0; p < NUM; p++) begin
      rem[p] = $urandom_range(1, 3);
      pos[p] = 0; started[p] = 0; xf[p] = 0;
      total += rem[p];
      for (int k = 0; k < rem[p]; k++) begin
        int len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          x.data = $urandom;
          x.keep = 4'($urandom_range(0, 15));
          x.user = 8'($urandom_range(0, 255));
          x.last = (b == len - 1);
          src_q[p].push_back(x);
        end
      end
    end
    while (total > 0) begin
      found = 0; sel = 0;
      for (int k = 0; k < NUM; k++)
        if (!found && rem[(ptr_m + k) % NUM] > 0) begin
          found = 1; sel = (ptr_m + k) % NUM;
        end
      do begin
        x = src_q[sel][pos[sel]];
        pos[sel]++;
        exp_b.push_back(x);
        exp_id.push_back(sel);
      end while (!x.last);
      rem[sel]--; total--;
      ptr_m = (sel + 1) % NUM;
    end

    apply_reset();
    for (int cyc = 0; cyc < 3000 && exp_b.size() > 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      for (int p = 0; p < NUM; p++)
        if (xf[p]) begin
          started[p] = !src_q[p][0].last;
          void'(src_q[p].pop_front());
          xf[p] = 0;
        end
      for (int p = 0; p < NUM; p++)
        if (src_q[p].size() > 0) drive_beat(p, started[p] ? ($urandom_range(0, 3) != 0) : 1'b1, src_q[p][0]);
        else                     drive_beat(p, 1'b0, '0);
      m_tready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if ($countones(s_tready) > 1) begin
        errors++; $display("FAIL rand_onehot cyc%0d: got s_tready=%b", cyc, s_tready);
      end
      if (hold_v) begin
        checks++;
        if ({m_tvalid, out_vec} !== held) begin
          errors++; $display("FAIL rand_stable cyc%0d: got %h want %h", cyc, {m_tvalid, out_vec}, held);
        end
      end
      hold_v = m_tvalid && !m_tready;
      held   = {m_tvalid, out_vec};
      if (m_tvalid && m_tready) begin
        eb  = exp_b.pop_front();
        eid = exp_id.pop_front();
        checks++;
        if (out_vec !== {eb.last, eb.data, eb.keep, eb.user, 2'(eid)}) begin
          errors++; $display("FAIL rand_beat cyc%0d: got %h want %h", cyc, out_vec,
                             {eb.last, eb.data, eb.keep, eb.user, 2'(eid)});
        end
      end
      for (int p = 0; p < NUM; p++) xf[p] = s_tvalid[p] && s_tready[p];
    end
    checks++;
    if (exp_b.size() != 0) begin
      errors++; $display("FAIL rand_timeout: %0d beats never appeared", exp_b.size());
    end
    @(negedge clk);
    s_tvalid = '0;
    m_tready = 1'b1;
    #1;
    checks++;
    if ({m_tvalid, busy} !== 2'b00) begin
      errors++; $display("FAIL rand_drain: got v=%b busy=%b want 0 0", m_tvalid, busy);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    m_tready = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_ptr_wrap();
    test_reset_mid_packet();
    for (int r = 0; r < 4; r++) test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
